// File: rtl/gpr_bank_responder_pkg.sv
// Shared widths, payload structs and FSM encoding for the GPR bank responder.
package gpr_bank_responder_pkg;

    localparam int unsigned ISSUE_WIS    = 4;
    localparam int unsigned SIMD_COUNT   = 2;
    localparam int unsigned SIMD_WIDTH   = 4;
    localparam int unsigned XLEN         = 32;
    localparam int unsigned NUM_REGS     = 64;
    localparam int unsigned NUM_SRC_OPDS = 3;
    localparam bit          ZERO_REG     = 1'b1;

    localparam int unsigned OPDW  = $clog2(NUM_SRC_OPDS);
    localparam int unsigned WISW  = (ISSUE_WIS > 1) ? $clog2(ISSUE_WIS) : 1;
    localparam int unsigned SIDW  = (SIMD_COUNT > 1) ? $clog2(SIMD_COUNT) : 1;
    localparam int unsigned REGW  = $clog2(NUM_REGS);
    localparam int unsigned ADDRW = WISW + SIDW + REGW;
    localparam int unsigned DEPTH = ISSUE_WIS * SIMD_COUNT * NUM_REGS;
    localparam int unsigned DATAW = SIMD_WIDTH * XLEN;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } gpr_state_e;

    typedef struct packed {
        logic [OPDW-1:0] opd_id;
        logic [WISW-1:0] wis;
        logic [SIDW-1:0] sid;
        logic [REGW-1:0] reg_id;
    } gpr_req_t;

    typedef struct packed {
        logic [OPDW-1:0]  opd_id;
        logic [DATAW-1:0] data;
    } gpr_rsp_t;

    typedef struct packed {
        logic [WISW-1:0]       wis;
        logic [SIDW-1:0]       sid;
        logic [REGW-1:0]       reg_id;
        logic [SIMD_WIDTH-1:0] tmask;
        logic [DATAW-1:0]      data;
    } gpr_wb_t;

    function automatic logic [ADDRW-1:0] gpr_addr(input logic [WISW-1:0] wis,
                                                  input logic [SIDW-1:0] sid,
                                                  input logic [REGW-1:0] reg_id);
        return {wis, sid, reg_id};
    endfunction

endpackage

// File: rtl/gpr_bank_responder_ram.sv
// 1R1W synchronous register storage with per-lane write enables; contents are never reset.
module gpr_bank_responder_ram
    import gpr_bank_responder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rd_en,
    input  logic [ADDRW-1:0]      rd_addr,
    output logic [DATAW-1:0]      rd_data,
    input  logic                  wr_en,
    input  logic [ADDRW-1:0]      wr_addr,
    input  logic [SIMD_WIDTH-1:0] wr_lane_en,
    input  logic [DATAW-1:0]      wr_data
);

    logic [DATAW-1:0] mem_q [DEPTH];
    logic [DATAW-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < SIMD_WIDTH; i++) begin
                if (wr_lane_en[i]) begin
                    mem_q[wr_addr][i*XLEN +: XLEN] <= wr_data[i*XLEN +: XLEN];
                end
            end
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/gpr_bank_responder.sv
// GPR request/response responder: zero-init sweep, 1-cycle reads with write-first bypass,
// masked writeback and a hard-wired zero register.
module gpr_bank_responder
    import gpr_bank_responder_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [OPDW-1:0]       req_opd_id,
    input  logic [WISW-1:0]       req_wis,
    input  logic [SIDW-1:0]       req_sid,
    input  logic [REGW-1:0]       req_reg_id,
    output logic                  rsp_valid,
    output logic [OPDW-1:0]       rsp_opd_id,
    output logic [DATAW-1:0]      rsp_data,
    input  logic                  wb_valid,
    input  logic [WISW-1:0]       wb_wis,
    input  logic [SIDW-1:0]       wb_sid,
    input  logic [REGW-1:0]       wb_reg_id,
    input  logic [SIMD_WIDTH-1:0] wb_tmask,
    input  logic [DATAW-1:0]      wb_data,
    output logic                  init_done
);

    gpr_state_e            state_q, state_d;
    logic [ADDRW-1:0]      cnt_q, cnt_d;
    logic                  req_ready_q, req_ready_d;
    logic                  init_done_q, init_done_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [OPDW-1:0]       rsp_opd_q, rsp_opd_d;
    logic                  has_rsp_q, has_rsp_d;
    logic                  zero_q, zero_d;
    logic [SIMD_WIDTH-1:0] byp_mask_q, byp_mask_d;
    logic [DATAW-1:0]      byp_data_q, byp_data_d;

    gpr_req_t              req_c;
    gpr_wb_t               wb_c;
    gpr_rsp_t              rsp_c;
    logic                  req_fire_c;
    logic                  wb_fire_c;
    logic [ADDRW-1:0]      req_addr_c;
    logic [ADDRW-1:0]      wb_addr_c;
    logic                  ram_wr_en_c;
    logic [ADDRW-1:0]      ram_wr_addr_c;
    logic [SIMD_WIDTH-1:0] ram_wr_lane_en_c;
    logic [DATAW-1:0]      ram_wr_data_c;
    logic [DATAW-1:0]      ram_rd_data;
    logic [DATAW-1:0]      merged_c;

    assign req_c      = '{opd_id: req_opd_id, wis: req_wis, sid: req_sid, reg_id: req_reg_id};
    assign wb_c       = '{wis: wb_wis, sid: wb_sid, reg_id: wb_reg_id, tmask: wb_tmask, data: wb_data};
    assign req_addr_c = gpr_addr(req_c.wis, req_c.sid, req_c.reg_id);
    assign wb_addr_c  = gpr_addr(wb_c.wis, wb_c.sid, wb_c.reg_id);
    assign req_fire_c = req_valid && req_ready_q;
    // Writes to the zero register never reach storage.
    assign wb_fire_c  = wb_valid && (state_q == ST_READY)
                        && !(ZERO_REG && (wb_c.reg_id == '0));

    // Sweep/ready FSM and storage write-port steering.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        req_ready_d      = req_ready_q;
        init_done_d      = init_done_q;
        ram_wr_en_c      = wb_fire_c;
        ram_wr_addr_c    = wb_addr_c;
        ram_wr_lane_en_c = wb_c.tmask;
        ram_wr_data_c    = wb_c.data;
        unique case (state_q)
            ST_INIT: begin
                ram_wr_en_c      = 1'b1;
                ram_wr_addr_c    = cnt_q;
                ram_wr_lane_en_c = '1;
                ram_wr_data_c    = '0;
                cnt_d            = cnt_q + ADDRW'(1);
                if (cnt_q == ADDRW'(DEPTH - 1)) begin
                    state_d     = ST_READY;
                    req_ready_d = 1'b1;
                    init_done_d = 1'b1;
                end
            end
            ST_READY: begin
                req_ready_d = 1'b1;
                init_done_d = 1'b1;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Response pipeline: capture tag, zero-reg flag and same-cycle write bypass at fire.
    always_comb begin
        rsp_valid_d = req_fire_c;
        rsp_opd_d   = rsp_opd_q;
        has_rsp_d   = has_rsp_q;
        zero_d      = zero_q;
        byp_mask_d  = byp_mask_q;
        byp_data_d  = byp_data_q;
        if (req_fire_c) begin
            rsp_opd_d  = req_c.opd_id;
            has_rsp_d  = 1'b1;
            zero_d     = ZERO_REG && (req_c.reg_id == '0);
            byp_mask_d = (wb_fire_c && (wb_addr_c == req_addr_c)) ? wb_c.tmask : '0;
            byp_data_d = wb_c.data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_opd_q   <= '0;
            has_rsp_q   <= 1'b0;
            zero_q      <= 1'b0;
            byp_mask_q  <= '0;
            byp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_opd_q   <= rsp_opd_d;
            has_rsp_q   <= has_rsp_d;
            zero_q      <= zero_d;
            byp_mask_q  <= byp_mask_d;
            byp_data_q  <= byp_data_d;
        end
    end

    gpr_bank_responder_ram u_ram (
        .clk        (clk),
        .rd_en      (req_fire_c),
        .rd_addr    (req_addr_c),
        .rd_data    (ram_rd_data),
        .wr_en      (ram_wr_en_c),
        .wr_addr    (ram_wr_addr_c),
        .wr_lane_en (ram_wr_lane_en_c),
        .wr_data    (ram_wr_data_c)
    );

    // RAM data is only trusted after a fire since reset; bypassed lanes override it.
    always_comb begin
        merged_c = ram_rd_data;
        for (int unsigned i = 0; i < SIMD_WIDTH; i++) begin
            if (byp_mask_q[i]) begin
                merged_c[i*XLEN +: XLEN] = byp_data_q[i*XLEN +: XLEN];
            end
        end
        rsp_c.opd_id = rsp_opd_q;
        rsp_c.data   = (has_rsp_q && !zero_q) ? merged_c : '0;
    end

    assign req_ready  = req_ready_q;
    assign init_done  = init_done_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_opd_id = rsp_c.opd_id;
    assign rsp_data   = rsp_c.data;

    // Writebacks arriving during the sweep are dropped.
    wb_during_init_a: assert property (@(posedge clk) disable iff (!reset)
        !(wb_valid && (state_q == ST_INIT)));

endmodule

// File: tb/tb_gpr_bank_responder.sv
// Randomised bench for gpr_bank_responder against a flat-array behavioural model.
module tb_gpr_bank_responder;
    import gpr_bank_responder_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  req_valid;
    logic                  req_ready;
    logic [OPDW-1:0]       req_opd_id;
    logic [WISW-1:0]       req_wis;
    logic [SIDW-1:0]       req_sid;
    logic [REGW-1:0]       req_reg_id;
    logic                  rsp_valid;
    logic [OPDW-1:0]       rsp_opd_id;
    logic [DATAW-1:0]      rsp_data;
    logic                  wb_valid;
    logic [WISW-1:0]       wb_wis;
    logic [SIDW-1:0]       wb_sid;
    logic [REGW-1:0]       wb_reg_id;
    logic [SIMD_WIDTH-1:0] wb_tmask;
    logic [DATAW-1:0]      wb_data;
    logic                  init_done;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    gpr_bank_responder dut (
        .clk        (clk),
        .reset      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opd_id (req_opd_id),
        .req_wis    (req_wis),
        .req_sid    (req_sid),
        .req_reg_id (req_reg_id),
        .rsp_valid  (rsp_valid),
        .rsp_opd_id (rsp_opd_id),
        .rsp_data   (rsp_data),
        .wb_valid   (wb_valid),
        .wb_wis     (wb_wis),
        .wb_sid     (wb_sid),
        .wb_reg_id  (wb_reg_id),
        .wb_tmask   (wb_tmask),
        .wb_data    (wb_data),
        .init_done  (init_done)
    );

    // Behavioural model: flat register array, ready after DEPTH cycles out of reset.
    logic [DATAW-1:0] m_mem [DEPTH];
    int unsigned      m_cycles;
    logic             exp_ready;
    logic             exp_rsp_valid;
    logic [OPDW-1:0]  exp_opd;
    logic [DATAW-1:0] exp_data;

    always @(posedge clk or negedge rst_n) begin : model
        int ra;
        int wa;
        logic [DATAW-1:0] rd;
        if (!rst_n) begin
            m_cycles      = 0;
            exp_ready     = 1'b0;
            exp_rsp_valid = 1'b0;
            exp_opd       = '0;
            exp_data      = '0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end else begin
            ra = int'(req_wis) * SIMD_COUNT * NUM_REGS + int'(req_sid) * NUM_REGS + int'(req_reg_id);
            wa = int'(wb_wis) * SIMD_COUNT * NUM_REGS + int'(wb_sid) * NUM_REGS + int'(wb_reg_id);
            if (req_valid && exp_ready) begin
                if (ZERO_REG && req_reg_id == 0) begin
                    rd = '0;
                end else begin
                    rd = m_mem[ra];
                    if (wb_valid && wb_reg_id != 0 && wa == ra)
                        for (int i = 0; i < SIMD_WIDTH; i++)
                            if (wb_tmask[i]) rd[i*XLEN +: XLEN] = wb_data[i*XLEN +: XLEN];
                end
                exp_rsp_valid = 1'b1;
                exp_opd       = req_opd_id;
                exp_data      = rd;
            end else begin
                exp_rsp_valid = 1'b0;
            end
            if (wb_valid && exp_ready && !(ZERO_REG && wb_reg_id == 0))
                for (int i = 0; i < SIMD_WIDTH; i++)
                    if (wb_tmask[i]) m_mem[wa][i*XLEN +: XLEN] = wb_data[i*XLEN +: XLEN];
            m_cycles++;
            exp_ready = (m_cycles >= DEPTH);
        end
    end

    task automatic chk(input string name, input logic [DATAW-1:0] act, input logic [DATAW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_req_ready", DATAW'(req_ready), DATAW'(exp_ready));
            chk("cyc_init_done", DATAW'(init_done), DATAW'(exp_ready));
            chk("cyc_rsp_valid", DATAW'(rsp_valid), DATAW'(exp_rsp_valid));
            chk("cyc_rsp_opd", DATAW'(rsp_opd_id), DATAW'(exp_opd));
            chk("cyc_rsp_data", rsp_data, exp_data);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        wb_valid  = 1'b0;
    endtask

    task automatic set_req(input int opd, input int wis, input int sid, input int rg);
        req_valid  = 1'b1;
        req_opd_id = OPDW'(opd);
        req_wis    = WISW'(wis);
        req_sid    = SIDW'(sid);
        req_reg_id = REGW'(rg);
    endtask

    task automatic set_wb(input int wis, input int sid, input int rg,
                          input logic [SIMD_WIDTH-1:0] tm, input logic [DATAW-1:0] d);
        wb_valid  = 1'b1;
        wb_wis    = WISW'(wis);
        wb_sid    = SIDW'(sid);
        wb_reg_id = REGW'(rg);
        wb_tmask  = tm;
        wb_data   = d;
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (!req_ready && n < 2000) begin
            step();
            n++;
        end
        chk(name, DATAW'(n), DATAW'(512));
        chk({name, "_done"}, DATAW'(init_done), DATAW'(1));
    endtask

    initial begin : stim
        int regs[6];
        regs = '{0, 1, 2, 3, 5, 7};
        rst_n = 1'b0;
        idle();
        req_opd_id = '0; req_wis = '0; req_sid = '0; req_reg_id = '0;
        wb_wis = '0; wb_sid = '0; wb_reg_id = '0; wb_tmask = '0; wb_data = '0;
        repeat (3) @(negedge clk);
        #1;
        cmp_en = 1'b1;
        chk("rst_rsp_valid", DATAW'(rsp_valid), DATAW'(0));
        chk("rst_rsp_data", rsp_data, '0);
        rst_n = 1'b1;

        // Sweep length and fresh read
        wait_init("init_cycles");
        set_req(1, 3, 1, 63);
        step(); idle();
        chk("t1_rsp_valid", DATAW'(rsp_valid), DATAW'(1));
        chk("t1_rsp_data", rsp_data, '0);

        // Write then read next cycle
        set_wb(1, 0, 5, 4'hF, {32'h44, 32'h33, 32'h22, 32'h11});
        step(); idle();
        set_req(2, 1, 0, 5);
        step(); idle();
        chk("t2_rsp_valid", DATAW'(rsp_valid), DATAW'(1));
        chk("t2_rsp_opd", DATAW'(rsp_opd_id), DATAW'(2));
        chk("t2_rsp_data", rsp_data, {32'h44, 32'h33, 32'h22, 32'h11});

        // Same-cycle read/partial write merge
        set_wb(2, 1, 7, 4'hF, {32'd4, 32'd3, 32'd2, 32'd1});
        step(); idle();
        set_req(0, 2, 1, 7);
        set_wb(2, 1, 7, 4'b0101, {32'hD, 32'hC, 32'hB, 32'hA});
        step(); idle();
        chk("t3_merge", rsp_data, {32'd4, 32'hC, 32'd2, 32'hA});
        set_req(1, 2, 1, 7);
        step(); idle();
        chk("t3_after", rsp_data, {32'd4, 32'hC, 32'd2, 32'hA});

        // Zero register
        set_wb(0, 0, 0, 4'hF, '1);
        step(); idle();
        set_req(2, 0, 0, 0);
        step(); idle();
        chk("t4_zero", rsp_data, '0);
        set_req(1, 0, 0, 0);
        set_wb(0, 0, 0, 4'hF, '1);
        step(); idle();
        chk("t4_zero_same", rsp_data, '0);

        // Back-to-back requests
        for (int i = 0; i < 6; i++) begin
            set_req(i % 3, i % 4, (i / 4) % 2, 10 + i);
            step();
            chk("t5_valid", DATAW'(rsp_valid), DATAW'(1));
            chk("t5_opd", DATAW'(rsp_opd_id), DATAW'(i % 3));
            chk("t5_data", rsp_data, '0);
        end
        idle();
        step();

        // Randomised traffic on a small address set to force collisions
        for (int c = 0; c < 400; c++) begin
            req_valid  = ($urandom_range(0, 3) != 0);
            req_opd_id = OPDW'($urandom_range(0, NUM_SRC_OPDS - 1));
            req_wis    = WISW'($urandom_range(0, ISSUE_WIS - 1));
            req_sid    = SIDW'($urandom_range(0, SIMD_COUNT - 1));
            req_reg_id = REGW'(regs[$urandom_range(0, 5)]);
            wb_valid   = ($urandom_range(0, 1) != 0);
            wb_wis     = WISW'($urandom_range(0, ISSUE_WIS - 1));
            wb_sid     = SIDW'($urandom_range(0, SIMD_COUNT - 1));
            wb_reg_id  = REGW'(regs[$urandom_range(0, 5)]);
            wb_tmask   = SIMD_WIDTH'($urandom_range(0, 15));
            for (int i = 0; i < SIMD_WIDTH; i++) wb_data[i*XLEN +: XLEN] = $urandom;
            step();
        end
        idle();
        set_wb(1, 0, 5, 4'hF, {4{32'hCAFE_F00D}});
        step(); idle();

        // Reset in flight
        set_req(0, 1, 0, 5);
        step(); idle();
        chk("t6_pre_valid", DATAW'(rsp_valid), DATAW'(1));
        rst_n = 1'b0;
        #1;
        chk("t6_drop_valid", DATAW'(rsp_valid), DATAW'(0));
        chk("t6_drop_ready", DATAW'(req_ready), DATAW'(0));
        step(); step();
        rst_n = 1'b1;
        wait_init("t6_init_cycles");
        set_req(1, 1, 0, 5);
        step(); idle();
        chk("t6_reinit_a", rsp_data, '0);
        set_req(2, 2, 1, 7);
        step(); idle();
        chk("t6_reinit_b", rsp_data, '0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
